vram_arbiter: RTL and testbench

Time-slot arbiter sharing the single 8-bit video SRAM between the 6845 CRTC character fetch and ISA CPU accesses. Each character clock (`divclk`) opens a slot of `SLOT_CYCLES` clk cycles:

- CRTC character and attribute bytes are fetched first, on fixed phases.
- One CPU read or write is serviced in the remaining window.
- The CPU is stalled through `cpu_wait` until its access completes.

The block sits between the CRTC/ISA decode logic and the SRAM pins.

---
 rtl/vram_arbiter_pkg.sv | 26 ++
 rtl/vram_slot_timer.sv | 52 +++++
 rtl/vram_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_vram_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_arbiter_pkg.sv
// vram_arbiter_pkg -- shared definitions for the video SRAM arbiter.
//   arb_state_t    : arbiter FSM state encoding
//   PH_CHAR        : slot phase at which the character byte address is driven
//   PH_CPU_FIRST   : first slot phase open to the CPU while the display is active
//   vid_byte_addr  : CRTC character address -> SRAM byte address (char/attr)
package vram_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_VID_CHAR  = 3'd1,
        ST_VID_ATTR  = 3'd2,
        ST_CPU_PEND  = 3'd3,
        ST_CPU_ISSUE = 3'd4,
        ST_CPU_DONE  = 3'd5
    } arb_state_t;

    localparam logic [3:0] PH_CHAR      = 4'd0;
    localparam logic [3:0] PH_CPU_FIRST = 4'd3;

    // Character bytes sit at even addresses, attribute bytes at the odd one above.
    function automatic logic [14:0] vid_byte_addr(input logic [13:0] mem_addr,
                                                  input logic        is_attr);
        return {mem_addr, is_attr};
    endfunction

endpackage

// File: rtl/vram_slot_timer.sv
// vram_slot_timer -- character-slot phase counter.
//   clk, reset      : clock, synchronous active-high reset
//   divclk          : character clock enable, restarts the slot at phase 0
//   display_enable  : CRTC display enable, sampled on divclk
//   in_window       : the NEXT clk cycle lies inside the CPU access window
// The window is reported one cycle ahead because the arbiter registers its
// SRAM outputs: a decision taken now becomes visible on the pins next cycle.
module vram_slot_timer
    import vram_arbiter_pkg::*;
#(
    parameter int SLOT_CYCLES = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic divclk,
    input  logic display_enable,
    output logic in_window
);

    localparam logic [3:0] PH_LAST = 4'(SLOT_CYCLES - 1);

    logic [3:0] phase_r;
    logic [3:0] phase_nxt_s;
    logic       disp_r;

    // Next phase without divclk (saturating) and window test on that phase.
    always_comb begin
        phase_nxt_s = (phase_r == PH_LAST) ? PH_LAST : (phase_r + 4'd1);
        if (divclk) begin
            in_window = 1'b0;
        end else if (disp_r) begin
            in_window = (phase_nxt_s >= PH_CPU_FIRST) && (phase_nxt_s < PH_LAST);
        end else begin
            in_window = (phase_nxt_s < PH_LAST);
        end
    end

    // Phase counter; resetting to the last phase keeps the SRAM quiet until
    // the first divclk.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_r <= PH_LAST;
            disp_r  <= 1'b0;
        end else if (divclk) begin
            phase_r <= PH_CHAR;
            disp_r  <= display_enable;
        end else begin
            phase_r <= phase_nxt_s;
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter -- time-slot arbiter for the 8-bit video SRAM shared by the
// CRTC character fetch and ISA CPU accesses.
//   clk, reset                     : clock, synchronous active-high reset
//   divclk, crtc_addr, display_enable : CRTC slot start, address, enable
//   cpu_req/we/addr/wdata          : CPU request (held until cpu_ready)
//   cpu_rdata/ready/wait           : CPU read data, completion pulse, ISA wait
//   ram_addr/we/oe/dout, ram_din   : SRAM pins (registered outputs)
//   char_byte, attr_byte, fetch_valid : fetched video bytes and update pulse
// ram_din is sampled on the clk edge that ends the cycle its address is driven.
module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter int SLOT_CYCLES = 8,
    parameter int AW          = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          divclk,
    input  logic [13:0]   crtc_addr,
    input  logic          display_enable,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_wdata,
    output logic [7:0]    cpu_rdata,
    output logic          cpu_ready,
    output logic          cpu_wait,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic          ram_oe,
    output logic [7:0]    ram_dout,
    input  logic [7:0]    ram_din,
    output logic [7:0]    char_byte,
    output logic [7:0]    attr_byte,
    output logic          fetch_valid
);

    arb_state_t    state_r, next_s;
    logic          in_window_s, win_s, accept_s;
    logic          slot_used_r, done_seen_r;
    logic          lat_we_r;
    logic [AW-1:0] lat_addr_r;
    logic [7:0]    lat_wdata_r;
    logic [13:0]   vid_addr_r;
    logic          eff_we_s;
    logic [AW-1:0] eff_addr_s;
    logic [7:0]    eff_wdata_s;
    logic [AW-1:0] addr_d_s;
    logic          oe_d_s, we_d_s;
    logic [7:0]    dout_d_s;

    vram_slot_timer #(.SLOT_CYCLES(SLOT_CYCLES)) u_timer (
        .clk            (clk),
        .reset          (reset),
        .divclk         (divclk),
        .display_enable (display_enable),
        .in_window      (in_window_s)
    );

    // done_seen blocks re-acceptance until cpu_req has been low for a cycle.
    assign cpu_wait = cpu_req & ~cpu_ready & ~done_seen_r;

    // Acceptance, window qualification and source of the access being issued.
    always_comb begin
        accept_s = cpu_req & ~done_seen_r & ~cpu_ready &
                   ((state_r == ST_IDLE) | (state_r == ST_VID_ATTR));
        win_s    = in_window_s & ~slot_used_r;
        // A request accepted this cycle may issue straight away, before the
        // latch holds it, so take it from the inputs.
        if (accept_s) begin
            eff_we_s    = cpu_we;
            eff_addr_s  = cpu_addr;
            eff_wdata_s = cpu_wdata;
        end else begin
            eff_we_s    = lat_we_r;
            eff_addr_s  = lat_addr_r;
            eff_wdata_s = lat_wdata_r;
        end
    end

    // Next-state logic; divclk overrides everything else.
    always_comb begin
        next_s = state_r;
        if (divclk) begin
            if (display_enable) begin
                next_s = ST_VID_CHAR;
            end else if (accept_s || (state_r == ST_CPU_PEND) || (state_r == ST_CPU_ISSUE)) begin
                next_s = ST_CPU_PEND;
            end else begin
                next_s = ST_IDLE;
            end
        end else begin
            case (state_r)
                ST_IDLE, ST_VID_ATTR: begin
                    if (accept_s) begin
                        next_s = win_s ? ST_CPU_ISSUE : ST_CPU_PEND;
                    end else begin
                        next_s = ST_IDLE;
                    end
                end
                ST_VID_CHAR:  next_s = ST_VID_ATTR;
                ST_CPU_PEND:  next_s = win_s ? ST_CPU_ISSUE : ST_CPU_PEND;
                ST_CPU_ISSUE: next_s = ST_CPU_DONE;
                ST_CPU_DONE:  next_s = ST_IDLE;
                default:      next_s = ST_IDLE;
            endcase
        end
    end

    // SRAM pin values for the state being entered.
    always_comb begin
        addr_d_s = '0;
        oe_d_s   = 1'b0;
        we_d_s   = 1'b0;
        dout_d_s = 8'h00;
        case (next_s)
            ST_VID_CHAR: begin
                addr_d_s = AW'(vid_byte_addr(crtc_addr, 1'b0));
                oe_d_s   = 1'b1;
            end
            ST_VID_ATTR: begin
                addr_d_s = AW'(vid_byte_addr(vid_addr_r, 1'b1));
                oe_d_s   = 1'b1;
            end
            ST_CPU_ISSUE: begin
                addr_d_s = eff_addr_s;
                if (eff_we_s) begin
                    we_d_s   = 1'b1;
                    dout_d_s = eff_wdata_s;
                end else begin
                    oe_d_s   = 1'b1;
                end
            end
            default: begin
                addr_d_s = '0;
            end
        endcase
    end

    // State, registered outputs, request latch and captures.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            ram_addr    <= '0;
            ram_oe      <= 1'b0;
            ram_we      <= 1'b0;
            ram_dout    <= 8'h00;
            char_byte   <= 8'h00;
            attr_byte   <= 8'h00;
            fetch_valid <= 1'b0;
            cpu_ready   <= 1'b0;
            cpu_rdata   <= 8'h00;
            lat_we_r    <= 1'b0;
            lat_addr_r  <= '0;
            lat_wdata_r <= 8'h00;
            vid_addr_r  <= 14'h0000;
            slot_used_r <= 1'b0;
            done_seen_r <= 1'b0;
        end else begin
            state_r     <= next_s;
            ram_addr    <= addr_d_s;
            ram_oe      <= oe_d_s;
            ram_we      <= we_d_s;
            ram_dout    <= dout_d_s;
            fetch_valid <= (state_r == ST_VID_ATTR);
            cpu_ready   <= (next_s == ST_CPU_DONE);
            done_seen_r <= cpu_req & (done_seen_r | cpu_ready);
            if (divclk) begin
                vid_addr_r <= crtc_addr;
            end
            if (state_r == ST_VID_CHAR) begin
                char_byte <= ram_din;
            end
            if (state_r == ST_VID_ATTR) begin
                attr_byte <= ram_din;
            end
            if ((state_r == ST_CPU_ISSUE) && (next_s == ST_CPU_DONE) && !lat_we_r) begin
                cpu_rdata <= ram_din;
            end
            if (accept_s && ((next_s == ST_CPU_PEND) || (next_s == ST_CPU_ISSUE))) begin
                lat_we_r    <= cpu_we;
                lat_addr_r  <= cpu_addr;
                lat_wdata_r <= cpu_wdata;
            end
            if (divclk) begin
                slot_used_r <= 1'b0;
            end else if (next_s == ST_CPU_ISSUE) begin
                slot_used_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter -- directed bench for vram_arbiter (SLOT_CYCLES = 8, AW = 15).
// The SRAM is modelled as a combinational read array; writes land on the
// clk edge at which ram_we is high. `ph` tracks the expected slot phase.
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        reset, divclk, display_enable;
    logic [13:0] crtc_addr;
    logic        cpu_req, cpu_we;
    logic [14:0] cpu_addr;
    logic [7:0]  cpu_wdata, cpu_rdata;
    logic        cpu_ready, cpu_wait;
    logic [14:0] ram_addr;
    logic        ram_we, ram_oe;
    logic [7:0]  ram_dout, ram_din;
    logic [7:0]  char_byte, attr_byte;
    logic        fetch_valid;

    logic [7:0]  mem [0:32767];
    int          checks = 0, errors = 0;
    int          we_cnt = 0, oe_cnt = 0, rdy_cnt = 0, overlap_cnt = 0;
    int          ph = 7;
    logic        auto_div = 1'b0;
    int          w0, o0, r0;

    vram_arbiter #(.SLOT_CYCLES(8), .AW(15)) dut (
        .clk            (clk),
        .reset          (reset),
        .divclk         (divclk),
        .crtc_addr      (crtc_addr),
        .display_enable (display_enable),
        .cpu_req        (cpu_req),
        .cpu_we         (cpu_we),
        .cpu_addr       (cpu_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_rdata      (cpu_rdata),
        .cpu_ready      (cpu_ready),
        .cpu_wait       (cpu_wait),
        .ram_addr       (ram_addr),
        .ram_we         (ram_we),
        .ram_oe         (ram_oe),
        .ram_dout       (ram_dout),
        .ram_din        (ram_din),
        .char_byte      (char_byte),
        .attr_byte      (attr_byte),
        .fetch_valid    (fetch_valid)
    );

    initial forever #5 clk = ~clk;

    assign ram_din = mem[ram_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clk: SRAM write and activity counters at the edge, then advance ph.
    task automatic tick();
        logic was_div;
        was_div = divclk;
        @(posedge clk);
        if (ram_we === 1'b1) begin
            mem[ram_addr] = ram_dout;
            we_cnt++;
        end
        if (ram_oe === 1'b1) oe_cnt++;
        if (cpu_ready === 1'b1) rdy_cnt++;
        if ((ram_we === 1'b1) && (ram_oe === 1'b1)) overlap_cnt++;
        #1;
        if (reset) ph = 7;
        else if (was_div) ph = 0;
        else if (ph != 7) ph++;
        divclk = auto_div && (ph == 7);
    endtask

    task automatic goto(input int p);
        for (int n = 0; (n < 20) && (ph != p); n++) tick();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_addr"},  32'(ram_addr),    32'h0);
        check({tag, "_we"},    32'(ram_we),      32'h0);
        check({tag, "_oe"},    32'(ram_oe),      32'h0);
        check({tag, "_dout"},  32'(ram_dout),    32'h0);
        check({tag, "_rdy"},   32'(cpu_ready),   32'h0);
        check({tag, "_wait"},  32'(cpu_wait),    32'h0);
        check({tag, "_rdata"}, 32'(cpu_rdata),   32'h0);
        check({tag, "_char"},  32'(char_byte),   32'h0);
        check({tag, "_attr"},  32'(attr_byte),   32'h0);
        check({tag, "_fv"},    32'(fetch_valid), 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 8'h00;
        mem[15'h0246] = 8'h41;
        mem[15'h0247] = 8'h07;
        mem[15'h1000] = 8'h5A;
        mem[15'h2000] = 8'hC3;
        reset = 1'b1; divclk = 1'b0; display_enable = 1'b0; crtc_addr = 14'h0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 15'h0; cpu_wdata = 8'h0;

        // Reset state
        tick();
        check_zero("rst");
        reset = 1'b0;
        tick(); tick();
        check("idle_oe", 32'(ram_oe), 32'h0);

        // Display active, CPU idle
        crtc_addr = 14'h0123; display_enable = 1'b1; auto_div = 1'b1; divclk = 1'b1;
        tick();
        check("v_ph0_addr", 32'(ram_addr), 32'h0246);
        check("v_ph0_oe",   32'(ram_oe),   32'h1);
        tick();
        check("v_ph1_addr", 32'(ram_addr), 32'h0247);
        check("v_ph1_char", 32'(char_byte), 32'h41);
        tick();
        check("v_ph2_fv",   32'(fetch_valid), 32'h1);
        check("v_ph2_char", 32'(char_byte), 32'h41);
        check("v_ph2_attr", 32'(attr_byte), 32'h07);
        tick();
        check("v_ph3_fv",   32'(fetch_valid), 32'h0);
        check("v_ph3_oe",   32'(ram_oe), 32'h0);
        check("v_we_cnt",   32'(we_cnt), 32'h0);

        // CPU read during active display, raised at phase 1
        goto(1);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h1000;
        #1;
        check("r_ph1_wait", 32'(cpu_wait), 32'h1);
        tick();
        check("r_ph2_wait", 32'(cpu_wait), 32'h1);
        check("r_ph2_oe",   32'(ram_oe),   32'h0);
        tick();
        check("r_ph3_addr", 32'(ram_addr), 32'h1000);
        check("r_ph3_oe",   32'(ram_oe),   32'h1);
        check("r_ph3_we",   32'(ram_we),   32'h0);
        check("r_ph3_wait", 32'(cpu_wait), 32'h1);
        check("r_ph3_rdy",  32'(cpu_ready), 32'h0);
        tick();
        check("r_ph4_rdy",   32'(cpu_ready), 32'h1);
        check("r_ph4_rdata", 32'(cpu_rdata), 32'h5A);
        check("r_ph4_wait",  32'(cpu_wait),  32'h0);
        cpu_req = 1'b0;
        tick();
        check("r_ph5_rdy",   32'(cpu_ready), 32'h0);
        check("r_ph5_rdata", 32'(cpu_rdata), 32'h5A);

        // CPU write in blanking, then held request
        display_enable = 1'b0;
        goto(0);
        check("b_ph0_oe", 32'(ram_oe), 32'h0);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0010; cpu_wdata = 8'h33;
        tick();
        check("b_ph1_we",   32'(ram_we),   32'h1);
        check("b_ph1_oe",   32'(ram_oe),   32'h0);
        check("b_ph1_addr", 32'(ram_addr), 32'h0010);
        check("b_ph1_dout", 32'(ram_dout), 32'h33);
        tick();
        check("b_ph2_rdy",  32'(cpu_ready), 32'h1);
        check("b_ph2_we",   32'(ram_we),    32'h0);
        check("b_ph2_dout", 32'(ram_dout),  32'h0);
        check("b_mem",      32'(mem[15'h0010]), 32'h33);
        tick();
        w0 = we_cnt; r0 = rdy_cnt;
        for (int i = 0; i < 20; i++) tick();
        check("h_we_cnt",  32'(we_cnt - w0),  32'h0);
        check("h_rdy_cnt", 32'(rdy_cnt - r0), 32'h0);
        check("h_wait",    32'(cpu_wait), 32'h0);
        cpu_req = 1'b0;
        tick();
        cpu_req = 1'b1; cpu_addr = 15'h0011; cpu_wdata = 8'h44;
        tick();
        check("h2_ph1_we",   32'(ram_we),   32'h1);
        check("h2_ph1_addr", 32'(ram_addr), 32'h0011);
        tick();
        check("h2_ph2_rdy", 32'(cpu_ready), 32'h1);
        cpu_req = 1'b0;
        check("h2_mem", 32'(mem[15'h0011]), 32'h44);

        // Late request at phase 7 of an active slot
        display_enable = 1'b1;
        goto(7);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h2000;
        o0 = oe_cnt; w0 = we_cnt;
        tick();
        check("l_ph0_addr", 32'(ram_addr), 32'h0246);
        check("l_ph0_wait", 32'(cpu_wait), 32'h1);
        tick(); tick();
        check("l_ph2_oe", 32'(ram_oe), 32'h0);
        tick();
        check("l_ph3_addr", 32'(ram_addr), 32'h2000);
        check("l_ph3_oe",   32'(ram_oe),   32'h1);
        tick();
        check("l_ph4_rdy",   32'(cpu_ready), 32'h1);
        check("l_ph4_rdata", 32'(cpu_rdata), 32'hC3);
        cpu_req = 1'b0;
        tick();
        check("l_oe_cnt", 32'(oe_cnt - o0), 32'h3);
        check("l_we_cnt", 32'(we_cnt - w0), 32'h0);

        // Reset in the middle of a write
        display_enable = 1'b0;
        goto(0);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0020; cpu_wdata = 8'h55;
        tick();
        check("x_ph1_we", 32'(ram_we), 32'h1);
        reset = 1'b1; cpu_req = 1'b0; auto_div = 1'b0;
        r0 = rdy_cnt;
        tick();
        check_zero("xr");
        reset = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0021; cpu_wdata = 8'h66;
        w0 = we_cnt;
        for (int i = 0; i < 5; i++) tick();
        check("x_pre_we",   32'(we_cnt - w0), 32'h0);
        check("x_pre_rdy",  32'(rdy_cnt - r0), 32'h0);
        check("x_pre_wait", 32'(cpu_wait), 32'h1);
        auto_div = 1'b1; divclk = 1'b1;
        tick();
        check("x_ph0_we", 32'(ram_we), 32'h0);
        tick();
        check("x_ph1_we",   32'(ram_we),   32'h1);
        check("x_ph1_addr", 32'(ram_addr), 32'h0021);
        check("x_ph1_dout", 32'(ram_dout), 32'h66);
        tick();
        check("x_ph2_rdy", 32'(cpu_ready), 32'h1);
        cpu_req = 1'b0;
        tick();
        check("x_we_cnt",  32'(we_cnt - w0), 32'h1);
        check("overlap",   32'(overlap_cnt), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
